// File: rtl/sfu_unit_scheduler.sv
// SFU issue-slot sharing: steers requests to sub-units under per-unit credit limits
// and merges their responses round-robin into one registered commit stream.

module sfu_credit_counter #(
    parameter int MAX_PENDING = 2,
    parameter int CNT_BITS    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                dec,
    output logic [CNT_BITS-1:0] cnt,
    output logic                credit_ok
);
    assign credit_ok = cnt < CNT_BITS'(MAX_PENDING);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            // A response with nothing outstanding is a sub-unit bug; hold at zero.
            assert (!(dec && !inc && cnt == '0));
            if (inc && !dec)
                cnt <= cnt + CNT_BITS'(1);
            else if (dec && !inc && cnt != '0)
                cnt <= cnt - CNT_BITS'(1);
        end
    end
endmodule

module sfu_unit_scheduler #(
    parameter int NUM_UNITS   = 2,
    parameter int REQ_DATAW   = 64,
    parameter int RSP_DATAW   = 64,
    parameter int MAX_PENDING = 2,
    localparam int UNIT_BITS  = $clog2(NUM_UNITS),
    localparam int CNT_BITS   = $clog2(MAX_PENDING + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    input  logic [UNIT_BITS-1:0]           req_unit,
    input  logic [REQ_DATAW-1:0]           req_data,
    output logic                           req_ready,
    output logic [NUM_UNITS-1:0]           unit_req_valid,
    output logic [REQ_DATAW-1:0]           unit_req_data,
    input  logic [NUM_UNITS-1:0]           unit_req_ready,
    input  logic [NUM_UNITS-1:0]           unit_rsp_valid,
    input  logic [NUM_UNITS*RSP_DATAW-1:0] unit_rsp_data,
    output logic [NUM_UNITS-1:0]           unit_rsp_ready,
    output logic                           rsp_valid,
    output logic [RSP_DATAW-1:0]           rsp_data,
    output logic [UNIT_BITS-1:0]           rsp_sel,
    input  logic                           rsp_ready,
    output logic                           bad_req,
    output logic                           idle
);
    logic [NUM_UNITS-1:0]               sel, credit_ok, inc, dec;
    logic [NUM_UNITS-1:0][CNT_BITS-1:0] pending;
    logic                               in_range;
    logic [UNIT_BITS-1:0]               ptr, grant_idx;
    logic                               found, load;
    logic [RSP_DATAW-1:0]               grant_data;

    function automatic logic [UNIT_BITS-1:0] wrap_add(input logic [UNIT_BITS-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= NUM_UNITS) s = s - NUM_UNITS;
        return UNIT_BITS'(s);
    endfunction

    // Extra bit keeps the range check meaningful when NUM_UNITS is a power of two.
    assign in_range = {1'b0, req_unit} < (UNIT_BITS + 1)'(NUM_UNITS);

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
        assign sel[i] = req_unit == UNIT_BITS'(i);
        sfu_credit_counter #(
            .MAX_PENDING(MAX_PENDING),
            .CNT_BITS   (CNT_BITS)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .inc      (inc[i]),
            .dec      (dec[i]),
            .cnt      (pending[i]),
            .credit_ok(credit_ok[i])
        );
    end

    assign unit_req_valid = {NUM_UNITS{req_valid}} & sel & credit_ok;
    assign unit_req_data  = req_data;
    assign req_ready      = in_range ? |(sel & unit_req_ready & credit_ok) : 1'b1;
    assign inc            = unit_req_valid & unit_req_ready;
    assign dec            = unit_rsp_valid & unit_rsp_ready;

    assign load = !rsp_valid || rsp_ready;
    assign idle = (pending == '0) && !rsp_valid;

    always_comb begin
        found          = 1'b0;
        grant_idx      = '0;
        grant_data     = '0;
        unit_rsp_ready = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!found && unit_rsp_valid[wrap_add(ptr, k)]) begin
                found     = 1'b1;
                grant_idx = wrap_add(ptr, k);
            end
        end
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant_idx == UNIT_BITS'(i))
                grant_data = unit_rsp_data[i*RSP_DATAW +: RSP_DATAW];
            unit_rsp_ready[i] = load && found && grant_idx == UNIT_BITS'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_sel   <= '0;
            ptr       <= '0;
            bad_req   <= 1'b0;
        end else begin
            bad_req <= req_valid && !in_range;
            if (load) begin
                rsp_valid <= found;
                if (found) begin
                    rsp_data <= grant_data;
                    rsp_sel  <= grant_idx;
                    ptr      <= wrap_add(grant_idx, 1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sfu_unit_scheduler.sv
// Directed bench for sfu_unit_scheduler with three sub-units and two credits each.

module tb_sfu_unit_scheduler;
    localparam int NU = 3;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic [1:0]      req_unit;
    logic [DW-1:0]   req_data;
    logic            req_ready;
    logic [NU-1:0]   unit_req_valid;
    logic [DW-1:0]   unit_req_data;
    logic [NU-1:0]   unit_req_ready;
    logic [NU-1:0]   unit_rsp_valid;
    logic [NU*DW-1:0] unit_rsp_data;
    logic [NU-1:0]   unit_rsp_ready;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_sel;
    logic            rsp_ready;
    logic            bad_req;
    logic            idle;

    int vectors = 0;
    int errors  = 0;

    sfu_unit_scheduler #(
        .NUM_UNITS(NU), .REQ_DATAW(DW), .RSP_DATAW(DW), .MAX_PENDING(2)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_unit(req_unit), .req_data(req_data), .req_ready(req_ready),
        .unit_req_valid(unit_req_valid), .unit_req_data(unit_req_data), .unit_req_ready(unit_req_ready),
        .unit_rsp_valid(unit_rsp_valid), .unit_rsp_data(unit_rsp_data), .unit_rsp_ready(unit_rsp_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_sel(rsp_sel), .rsp_ready(rsp_ready),
        .bad_req(bad_req), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_unit = '0; req_data = '0;
        unit_req_ready = '0; unit_rsp_valid = '0; unit_rsp_data = '0; rsp_ready = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h want 0", rsp_valid); end
        vectors++; if (rsp_sel !== 2'd0) begin errors++; $display("FAIL reset_rsp_sel got %0h want 0", rsp_sel); end
        vectors++; if (rsp_data !== 64'd0) begin errors++; $display("FAIL reset_rsp_data got %0h want 0", rsp_data); end
        vectors++; if (bad_req !== 1'b0) begin errors++; $display("FAIL reset_bad_req got %0h want 0", bad_req); end
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %0h want 1", idle); end
        req_valid = 1'b1; req_unit = 2'd1; req_data = 64'hDEAD_BEEF; unit_req_ready = 3'b010;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready_hi got %0h want 1", req_ready); end
        vectors++; if (unit_req_valid !== 3'b010) begin errors++; $display("FAIL reset_unit_req_valid got %0h want 2", unit_req_valid); end
        vectors++; if (unit_req_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL reset_unit_req_data got %0h want deadbeef", unit_req_data); end
        unit_req_ready = 3'b101;
        #1;
        vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready_lo got %0h want 0", req_ready); end
        vectors++; if (unit_req_valid !== 3'b010) begin errors++; $display("FAIL reset_valid_no_ready_dep got %0h want 2", unit_req_valid); end
        req_valid = 1'b0;
    endtask

    task automatic test_credit();
        unit_req_ready = 3'b111; req_valid = 1'b1; req_unit = 2'd1; rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL credit_accept%0d got %0h want 1", k, req_ready); end
            step();
        end
        #1;
        vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL credit_full_ready got %0h want 0", req_ready); end
        vectors++; if (unit_req_valid !== 3'b000) begin errors++; $display("FAIL credit_full_valid got %0h want 0", unit_req_valid); end
        vectors++; if (idle !== 1'b0) begin errors++; $display("FAIL credit_busy_idle got %0h want 0", idle); end
        req_unit = 2'd0;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL credit_other_unit got %0h want 1", req_ready); end
        req_unit = 2'd1;
        unit_rsp_valid = 3'b010; unit_rsp_data[DW +: DW] = 64'h1234;
        #1;
        vectors++; if (unit_rsp_ready !== 3'b010) begin errors++; $display("FAIL credit_rsp_ready got %0h want 2", unit_rsp_ready); end
        step();
        unit_rsp_valid = 3'b000;
        #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_sel !== 2'd1 || rsp_data !== 64'h1234) begin
            errors++; $display("FAIL credit_rsp got v%0h s%0h d%0h want v1 s1 d1234", rsp_valid, rsp_sel, rsp_data); end
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL credit_freed got %0h want 1", req_ready); end
        step();
        #1;
        vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL credit_refull got %0h want 0", req_ready); end
        req_valid = 1'b0;
        unit_rsp_valid = 3'b010;
        step(); step();
        unit_rsp_valid = 3'b000;
        step();
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL credit_drain_idle got %0h want 1", idle); end
    endtask

    task automatic test_round_robin();
        logic [1:0]    exp_sel;
        logic [DW-1:0] exp_data;
        unit_req_ready = 3'b111; req_valid = 1'b1;
        req_unit = 2'd0; step(); step();
        req_unit = 2'd1; step(); step();
        req_valid = 1'b0; rsp_ready = 1'b1;
        unit_rsp_valid = 3'b011;
        for (int k = 0; k < 4; k++) begin
            unit_rsp_data[0 +: DW]  = 64'h100 + 64'(k);
            unit_rsp_data[DW +: DW] = 64'h200 + 64'(k);
            exp_sel  = (k % 2 == 0) ? 2'd0 : 2'd1;
            exp_data = (k % 2 == 0) ? 64'h100 + 64'(k) : 64'h200 + 64'(k);
            #1;
            vectors++; if (unit_rsp_ready !== ((k % 2 == 0) ? 3'b001 : 3'b010)) begin
                errors++; $display("FAIL rr_grant%0d got %0h", k, unit_rsp_ready); end
            step();
            vectors++; if (rsp_valid !== 1'b1 || rsp_sel !== exp_sel || rsp_data !== exp_data) begin
                errors++; $display("FAIL rr_rsp%0d got v%0h s%0h d%0h want v1 s%0h d%0h", k, rsp_valid, rsp_sel, rsp_data, exp_sel, exp_data); end
        end
        unit_rsp_valid = 3'b000;
        step();
        vectors++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL rr_drain got v%0h idle%0h want v0 idle1", rsp_valid, idle); end
    endtask

    task automatic test_backpressure();
        unit_req_ready = 3'b111; req_valid = 1'b1;
        req_unit = 2'd1; step();
        req_unit = 2'd0; step();
        req_valid = 1'b0;
        rsp_ready = 1'b0; unit_rsp_valid = 3'b010; unit_rsp_data[DW +: DW] = 64'hA5;
        step();
        unit_rsp_valid = 3'b001; unit_rsp_data[0 +: DW] = 64'h5A; unit_rsp_data[DW +: DW] = 64'hFF;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (unit_rsp_ready !== 3'b000) begin errors++; $display("FAIL bp_rsp_ready%0d got %0h want 0", k, unit_rsp_ready); end
            vectors++; if (rsp_valid !== 1'b1 || rsp_sel !== 2'd1 || rsp_data !== 64'hA5) begin
                errors++; $display("FAIL bp_hold%0d got v%0h s%0h d%0h want v1 s1 da5", k, rsp_valid, rsp_sel, rsp_data); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        vectors++; if (unit_rsp_ready !== 3'b001) begin errors++; $display("FAIL bp_release_grant got %0h want 1", unit_rsp_ready); end
        step();
        unit_rsp_valid = 3'b000;
        vectors++; if (rsp_sel !== 2'd0 || rsp_data !== 64'h5A) begin errors++; $display("FAIL bp_next got s%0h d%0h want s0 d5a", rsp_sel, rsp_data); end
        step();
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL bp_idle got %0h want 1", idle); end
    endtask

    task automatic test_same_cycle();
        unit_req_ready = 3'b111; req_valid = 1'b1; req_unit = 2'd0; rsp_ready = 1'b1;
        step();
        unit_rsp_valid = 3'b001; unit_rsp_data[0 +: DW] = 64'h77;
        #1;
        vectors++; if (req_ready !== 1'b1 || unit_rsp_ready !== 3'b001) begin
            errors++; $display("FAIL same_handshake got rr%0h urr%0h want rr1 urr1", req_ready, unit_rsp_ready); end
        step();
        unit_rsp_valid = 3'b000;
        #1;
        vectors++; if (req_ready !== 1'b1 || idle !== 1'b0) begin
            errors++; $display("FAIL same_pending1 got rr%0h idle%0h want rr1 idle0", req_ready, idle); end
        req_valid = 1'b0;
        unit_rsp_valid = 3'b001;
        step();
        unit_rsp_valid = 3'b000;
        #1;
        vectors++; if (idle !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL same_rsp_pending got idle%0h v%0h want idle0 v1", idle, rsp_valid); end
        step();
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL same_idle got %0h want 1", idle); end
    endtask

    task automatic test_bad_req();
        unit_req_ready = 3'b111; req_valid = 1'b1; req_unit = 2'd3;
        #1;
        vectors++; if (req_ready !== 1'b1 || unit_req_valid !== 3'b000) begin
            errors++; $display("FAIL bad_accept got rr%0h urv%0h want rr1 urv0", req_ready, unit_req_valid); end
        vectors++; if (bad_req !== 1'b0) begin errors++; $display("FAIL bad_early got %0h want 0", bad_req); end
        step();
        req_valid = 1'b0;
        vectors++; if (bad_req !== 1'b1 || idle !== 1'b1) begin errors++; $display("FAIL bad_pulse got %0h idle%0h want 1 idle1", bad_req, idle); end
        step();
        vectors++; if (bad_req !== 1'b0) begin errors++; $display("FAIL bad_one_cycle got %0h want 0", bad_req); end
    endtask

    task automatic test_reset_mid_burst();
        unit_req_ready = 3'b111; req_valid = 1'b1; rsp_ready = 1'b0;
        req_unit = 2'd0; step(); step();
        req_unit = 2'd1; step();
        req_valid = 1'b0;
        unit_rsp_valid = 3'b010; unit_rsp_data[DW +: DW] = 64'hCC;
        step();
        unit_rsp_valid = 3'b000;
        req_valid = 1'b1; req_unit = 2'd0;
        #1;
        vectors++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL mid_setup got v%0h rr%0h want v1 rr0", rsp_valid, req_ready); end
        reset = 1'b0;
        step();
        vectors++; if (rsp_valid !== 1'b0 || rsp_data !== 64'd0 || rsp_sel !== 2'd0 || idle !== 1'b1) begin
            errors++; $display("FAIL mid_reset got v%0h d%0h s%0h idle%0h want v0 d0 s0 idle1", rsp_valid, rsp_data, rsp_sel, idle); end
        reset = 1'b1;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_credit_restored got %0h want 1", req_ready); end
        req_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_credit();
        test_round_robin();
        test_backpressure();
        test_same_cycle();
        test_bad_req();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/sfu_unit_scheduler.md
Name: sfu_unit_scheduler

Overview:
- Shares the SFU issue slot between NUM_UNITS sub-units (warp control, CSR, future additions) and merges their commit streams.
- Steers each dispatched request to the sub-unit selected by req_unit.
- Bounds the in-flight requests per sub-unit with credit counters.
- Arbitrates sub-unit responses round-robin into one registered commit stream toward the gather stage.

Parameters:
- NUM_UNITS, 2, number of sub-units; minimum 2.
- REQ_DATAW, 64, request payload width.
- RSP_DATAW, 64, response payload width.
- MAX_PENDING, 2, maximum in-flight requests per sub-unit; minimum 1.
- Derived: UNIT_BITS = CLOG2(NUM_UNITS); CNT_BITS = CLOG2(MAX_PENDING+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  dispatch request valid.
- req_unit  in  UNIT_BITS  target sub-unit index.
- req_data  in  REQ_DATAW  request payload.
- req_ready  out  1  request accepted.
- unit_req_valid  out  NUM_UNITS  per-unit request valid.
- unit_req_data  out  REQ_DATAW  payload, broadcast to all units.
- unit_req_ready  in  NUM_UNITS  per-unit request ready.
- unit_rsp_valid  in  NUM_UNITS  per-unit response valid.
- unit_rsp_data  in  NUM_UNITS*RSP_DATAW  responses; unit i occupies bits [i*RSP_DATAW +: RSP_DATAW].
- unit_rsp_ready  out  NUM_UNITS  per-unit response ready.
- rsp_valid  out  1  merged response valid.
- rsp_data  out  RSP_DATAW  merged response payload.
- rsp_sel  out  UNIT_BITS  source unit of the current rsp_data.
- rsp_ready  in  1  downstream ready.
- bad_req  out  1  one-cycle pulse when an out-of-range req_unit is consumed.
- idle  out  1  all counters zero and rsp_valid low.

Behaviour:
- Reset (reset==0 at a clk edge):
  - rsp_valid=0, rsp_sel=0, rsp_data=0, bad_req=0.
  - All pending counters 0; round-robin pointer 0; idle=1 from the following cycle.
  - Takes precedence over any simultaneous handshake; in-flight requests are forgotten (sub-units are reset alongside).
- Request path, combinational, zero latency:
  - credit_ok[i] = pending[i] < MAX_PENDING.
  - unit_req_valid[i] = req_valid && req_unit==i && credit_ok[i].
  - unit_req_data = req_data.
  - req_ready = unit_req_ready[req_unit] && credit_ok[req_unit] when req_unit < NUM_UNITS; otherwise req_ready=1.
  - Out-of-range request: consumed and dropped; bad_req=1 on the next cycle for exactly one cycle; no counter changes.
  - No unit_req_valid depends on unit_req_ready (no combinational loop).
- Credit counters (one per unit):
  - +1 on unit_req_valid[i]&&unit_req_ready[i]; -1 on unit_rsp_valid[i]&&unit_rsp_ready[i].
  - Both in the same cycle: unchanged.
  - At MAX_PENDING, unit_req_valid[i] is held low and req_ready is low for requests targeting unit i; other units proceed unblocked.
  - Response with pending[i]==0 is a protocol violation: counter holds at 0 and a simulation assertion fires.
- Response arbitration:
  - load = !rsp_valid || rsp_ready.
  - Grant: among units with unit_rsp_valid set, the first one at or after the pointer (wrapping).
  - unit_rsp_ready[i] = load && grant[i]; at most one bit set.
  - On a grant edge: rsp_valid<=1, rsp_data<=unit_rsp_data[g], rsp_sel<=g, pointer<=(g+1) mod NUM_UNITS.
  - On load with no valid inputs: rsp_valid<=0; pointer unchanged.
  - Latency: 1 cycle from unit response accept to rsp_valid. Full throughput, one response per cycle under continuous rsp_ready.
  - While rsp_valid && !rsp_ready: rsp_data and rsp_sel are held stable; no unit_rsp_ready is asserted.
- idle is combinational: all pending==0 && !rsp_valid.

Test Plan:
- Reset release, no traffic -> idle=1, rsp_valid=0, req_ready follows unit_req_ready of the selected unit; bad_req=0.
- MAX_PENDING=2; 3 back-to-back requests to unit 1 with unit_req_ready=1 and no responses -> first two accepted, third sees req_ready=0. One unit-1 response then frees the slot: third accepted the next cycle, pending[1]=2.
- Units 0 and 1 both hold rsp valid continuously, rsp_ready=1 -> rsp_sel sequence 0,1,0,1; one response per cycle; each rsp_data matches its source payload.
- rsp_ready=0 for 3 cycles with rsp_valid=1 (data 0xA5, sel=1) -> rsp_data and rsp_sel stable; unit_rsp_ready all 0. On release, the next grant occurs in that same cycle.
- Same-cycle request accept and response accept on unit 0 with pending[0]=1 -> pending[0] stays 1; then the response alone -> 0 and idle=1 once rsp drains.
- NUM_UNITS=3, req_unit=3 -> req_ready=1, no unit_req_valid, bad_req high for exactly 1 cycle. reset low mid-burst with pending=2 and rsp_valid=1 -> next cycle all zero, idle=1.
